tx_frame_arbiter: RTL and testbench
===================================

// Module: tx_frame_arbiter
// PURPOSE
//  Parametrised successor to the single-channel Tx packetizer path. Takes N_CH byte-wide AXI-Stream payload
//  sources, picks one per frame by round-robin, and emits preamble + header + payload (+ optional CRC) on one
//  AXI-Stream to PSK_Modulation / Bits_Flatten. Sits between the per-channel FIFOs and the modulator,
//  single 1.024 MHz domain.
// PARAMETERS
//  N_CH          2     number of input channels (1..8)
//  PREAMBLE_LEN  4     preamble bytes per frame (1..16)
//  PREAMBLE_BYTE 8'h55 preamble pattern
//  LEN_W         16    payload length field width; header carries it MSB byte first, 2 bytes
//  MAX_LEN       1024  length clamp; requested length > MAX_LEN is sent as MAX_LEN
//  PAD_BYTE      8'h00 filler when source ends early
// PORTS
//  clk             in   1          system clock (clk_1M024 at top)
//  rst_n           in   1          asynchronous active-low reset
//  enable          in   1          0: no new grant; frame in flight completes
//  s_tdata         in   N_CH*8     channel payload bytes, ch i at [8i+:8]
//  s_tvalid        in   N_CH       per-channel valid
//  s_tready        out  N_CH       per-channel ready, only granted channel may be 1
//  s_tlast         in   N_CH       per-channel end of payload
//  s_len           in   N_CH*LEN_W per-channel payload length, sampled at grant
//  m_tdata         out  8          frame byte
//  m_tvalid        out  1          frame byte valid
//  m_tready        in   1          downstream ready
//  m_tlast         out  1          last byte of frame
//  m_tuser         out  1          1 on preamble/header bytes (Bits_Flatten bypass), 0 on payload/CRC
//  hdr_vld         out  1          byte on m_tdata is header (ch-id or length byte)
//  pld_vld         out  1          byte on m_tdata is payload
//  cur_ch          out  3          granted channel index
//  pkt_sent        out  1          1-cycle pulse when last byte accepted (m_tvalid&m_tready&m_tlast)
//  err_short       out  1          1-cycle pulse: s_tlast before length reached (padding applied)
//  err_long        out  1          1-cycle pulse: length reached without s_tlast (drain applied)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, out register empty.
//  Out register: one stage; loads when empty or m_tready; m_tvalid held with stable data until accepted.
//  FSM: IDLE -> PRE -> HDR -> PLD -> (CRC) -> IDLE; DRAIN entered from PLD/CRC completion on err_long.
//  IDLE: if enable & |s_tvalid, grant first valid channel at/after rr ptr (wrap N_CH-1 -> 0); latch
//   len=min(s_len,MAX_LEN); ptr<=grant+1 mod N_CH. First preamble byte valid next cycle.
//  PRE: PREAMBLE_LEN x PREAMBLE_BYTE. HDR: {5'b0,cur_ch}, len[15:8], len[7:0]; m_tuser=1 in PRE/HDR.
//  PLD: s_tready[g]=out-reg-loadable; byte counter to len; counter width LEN_W, never wraps.
//  s_tlast on byte k<len: accept it, err_short pulse, remaining len-k bytes = PAD_BYTE, s_tready=0.
//  Counter hits len with no s_tlast: frame closes normally, err_long pulse, DRAIN: s_tready[g]=1
//   until s_tlast accepted, bytes discarded, no new grant before drain ends.
//  len=0: HDR last byte goes straight to CRC (or is m_tlast without CRC); no payload read.
//  m_tlast on final byte only; pkt_sent on its acceptance; IDLE re-grants same cycle as pkt_sent+1.
//  enable deassert mid-frame: ignored until IDLE. rst_n assert mid-frame: immediate abort, all to reset.
//  Simultaneous s_tvalid on all channels: strict rotation, one frame each.
// CONFIGURATION
//  TX_FRAME_CRC_EN defined: CRC-16-CCITT (poly 16'h1021, init 16'hFFFF, no reflect, no xorout) over
//   header+payload (pad included), appended MSB first, m_tuser=0; m_tlast on CRC low byte.
//  Undefined: no CRC state/logic; m_tlast on last payload byte (or last header byte if len=0).
// STRUCTURE
//  Package tx_frame_pkg: state encoding localparams, CRC_POLY, CRC_INIT, HDR_BYTES=3, CH_ID_W=3.
//  Sub-module crc16_ccitt_byte: combinational next-CRC from {crc,byte}; only built under TX_FRAME_CRC_EN.
// TESTING
//  N_CH=2, ch0 len=3 data 01 02 03 tlast on 03 -> 55 55 55 55 00 00 03 01 02 03 (+CRC), pkt_sent 1 pulse.
//  ch0,ch1 both valid continuously -> frame ch-ids 00,01,00,01; no starvation; cur_ch matches header.
//  len=4, tlast on 2nd byte -> payload AA BB 00 00, err_short pulse, s_tready low after tlast.
//  len=2, source sends 5 bytes -> 2 payload bytes out, err_long, 3 bytes drained, next grant after.
//  m_tready toggled 50% random -> byte sequence unchanged, m_tdata stable while m_tvalid&!m_tready.
//  CRC_EN, len=0, ch1 -> header 01 00 00 then CRC of {01,00,00} MSB first, m_tlast on final byte.

Source files
------------

// File: rtl/tx_frame_pkg.sv
// Package: tx_frame_pkg
// Shared definitions for the multi-channel Tx frame arbiter.
//   state_t        frame FSM state encoding (S_CRC exists only when TX_FRAME_CRC_EN is defined)
//   CRC_POLY/INIT  CRC-16-CCITT polynomial and seed
//   HDR_BYTES      header length: channel id, length MSB, length LSB
//   CH_ID_W        width of the channel index carried in the header and on cur_ch
package tx_frame_pkg;

    localparam int unsigned HDR_BYTES = 3;
    localparam int unsigned CH_ID_W   = 3;
    localparam logic [15:0] CRC_POLY  = 16'h1021;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_HDR   = 3'd2,
        S_PLD   = 3'd3,
`ifdef TX_FRAME_CRC_EN
        S_CRC   = 3'd4,
`endif
        S_DRAIN = 3'd5
    } state_t;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Module: crc16_ccitt_byte
// Combinational CRC-16-CCITT advance by one byte, MSB first, no reflection.
// Only instantiated when TX_FRAME_CRC_EN is defined.
//   crc_in   [15:0]  current CRC
//   data_in  [7:0]   byte to fold in
//   crc_out  [15:0]  CRC after data_in
module crc16_ccitt_byte
    import tx_frame_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {data_in, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Module: tx_frame_arbiter
// Round-robin arbiter/packetizer: picks one of N_CH byte-wide AXI-Stream sources per frame and
// emits preamble + header {ch, len MSB, len LSB} + payload (+ CRC-16 when TX_FRAME_CRC_EN is defined)
// on a single AXI-Stream through a one-stage output register.
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              gates new grants only; a frame in flight always completes
//   s_tdata/tvalid/tready/tlast/len   per-channel payload sources, channel i at slice i
//   m_tdata/tvalid/tready/tlast       frame output stream
//   m_tuser             1 on preamble/header bytes
//   hdr_vld, pld_vld    byte-type qualifiers for the current m_tdata
//   cur_ch              granted channel
//   pkt_sent            last frame byte accepted
//   err_short/err_long  source ended early (padded) / source overran length (drained)
// Optional feature macro: TX_FRAME_CRC_EN
module tx_frame_arbiter
    import tx_frame_pkg::*;
#(
    parameter int unsigned N_CH          = 2,
    parameter int unsigned PREAMBLE_LEN  = 4,
    parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
    parameter int unsigned LEN_W         = 16,
    parameter int unsigned MAX_LEN       = 1024,
    parameter logic [7:0]  PAD_BYTE      = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [N_CH*8-1:0]     s_tdata,
    input  logic [N_CH-1:0]       s_tvalid,
    output logic [N_CH-1:0]       s_tready,
    input  logic [N_CH-1:0]       s_tlast,
    input  logic [N_CH*LEN_W-1:0] s_len,
    output logic [7:0]            m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  m_tuser,
    output logic                  hdr_vld,
    output logic                  pld_vld,
    output logic [CH_ID_W-1:0]    cur_ch,
    output logic                  pkt_sent,
    output logic                  err_short,
    output logic                  err_long
);

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [4:0]       PRE_LAST  = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0]       HDR_LAST  = 5'(HDR_BYTES - 1);

    state_t             state_q, state_d;
    logic [4:0]         idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
    logic               pad_q, pad_d;
    logic [CH_ID_W-1:0] ptr_q, ptr_d, cur_ch_d;

    logic               load_ok, last_pld, pld_step;
    logic               byte_vld, byte_last, byte_user, byte_hdr, byte_pld;
    logic [7:0]         byte_data;
    logic               short_d, long_d;
    logic [15:0]        hdr_len;

    logic               grant_vld;
    logic [CH_ID_W-1:0] grant_ch;
    logic [LEN_W-1:0]   grant_len;
    int                 off, best_off;

    logic               sel_valid, sel_last, sel_ready;
    logic [7:0]         sel_data;

    // Output register accepts a new byte when empty or when its current byte leaves this cycle.
    assign load_ok  = !m_tvalid || m_tready;
    assign pkt_sent = m_tvalid && m_tready && m_tlast;
    assign last_pld = (cnt_q == len_q - 1'b1);
    assign hdr_len  = 16'(len_q);

    // Round-robin: smallest rotation distance from ptr_q among valid channels wins.
    always_comb begin
        grant_vld = |s_tvalid;
        grant_ch  = '0;
        grant_len = '0;
        best_off  = int'(N_CH);
        off       = 0;
        for (int j = 0; j < int'(N_CH); j++) begin
            off = (j + int'(N_CH) - int'(ptr_q)) % int'(N_CH);
            if (s_tvalid[j] && off < best_off) begin
                best_off  = off;
                grant_ch  = CH_ID_W'(j);
                grant_len = s_len[j*LEN_W +: LEN_W];
            end
        end
    end

    // Granted-channel source mux and ready demux.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        s_tready  = '0;
        for (int j = 0; j < int'(N_CH); j++) begin
            if (cur_ch == CH_ID_W'(j)) begin
                sel_valid   = s_tvalid[j];
                sel_last    = s_tlast[j];
                sel_data    = s_tdata[j*8 +: 8];
                s_tready[j] = sel_ready;
            end
        end
    end

`ifdef TX_FRAME_CRC_EN
    logic [15:0] crc_q, crc_next;
    logic        drain_q, drain_d;

    crc16_ccitt_byte u_crc (
        .crc_in  (crc_q),
        .data_in (byte_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q   <= CRC_INIT;
            drain_q <= 1'b0;
        end else begin
            drain_q <= drain_d;
            if (state_q == S_IDLE && byte_vld)
                crc_q <= CRC_INIT;
            else if (load_ok && (byte_hdr || byte_pld))
                crc_q <= crc_next;
        end
    end
`endif

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        pad_d     = pad_q;
        ptr_d     = ptr_q;
        cur_ch_d  = cur_ch;
        byte_vld  = 1'b0;
        byte_data = 8'h00;
        byte_user = 1'b0;
        byte_hdr  = 1'b0;
        byte_pld  = 1'b0;
        byte_last = 1'b0;
        sel_ready = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        pld_step  = 1'b0;
`ifdef TX_FRAME_CRC_EN
        drain_d   = drain_q;
`endif
        case (state_q)
            S_IDLE: begin
                // The first preamble byte is loaded in the grant cycle itself.
                if (enable && grant_vld && load_ok) begin
                    cur_ch_d  = grant_ch;
                    ptr_d     = CH_ID_W'((int'(grant_ch) + 1) % int'(N_CH));
                    len_d     = (grant_len > MAX_LEN_V) ? MAX_LEN_V : grant_len;
                    cnt_d     = '0;
                    pad_d     = 1'b0;
`ifdef TX_FRAME_CRC_EN
                    drain_d   = 1'b0;
`endif
                    byte_vld  = 1'b1;
                    byte_data = PREAMBLE_BYTE;
                    byte_user = 1'b1;
                    if (PREAMBLE_LEN == 1) begin
                        state_d = S_HDR;
                        idx_d   = '0;
                    end else begin
                        state_d = S_PRE;
                        idx_d   = 5'd1;
                    end
                end
            end
            S_PRE: begin
                if (load_ok) begin
                    byte_vld  = 1'b1;
                    byte_data = PREAMBLE_BYTE;
                    byte_user = 1'b1;
                    if (idx_q == PRE_LAST) begin
                        state_d = S_HDR;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_HDR: begin
                if (load_ok) begin
                    byte_vld  = 1'b1;
                    byte_user = 1'b1;
                    byte_hdr  = 1'b1;
                    if (idx_q == 5'd0)      byte_data = 8'(cur_ch);
                    else if (idx_q == 5'd1) byte_data = hdr_len[15:8];
                    else                    byte_data = hdr_len[7:0];
                    if (idx_q == HDR_LAST) begin
                        idx_d = '0;
                        if (len_q == '0) begin
`ifdef TX_FRAME_CRC_EN
                            state_d = S_CRC;
`else
                            byte_last = 1'b1;
                            state_d   = S_IDLE;
`endif
                        end else begin
                            state_d = S_PLD;
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_PLD: begin
                if (pad_q) begin
                    if (load_ok) begin
                        byte_vld  = 1'b1;
                        byte_data = PAD_BYTE;
                        byte_pld  = 1'b1;
                        pld_step  = 1'b1;
                    end
                end else begin
                    sel_ready = load_ok;
                    if (load_ok && sel_valid) begin
                        byte_vld  = 1'b1;
                        byte_data = sel_data;
                        byte_pld  = 1'b1;
                        pld_step  = 1'b1;
                        if (sel_last && !last_pld) begin
                            pad_d   = 1'b1;
                            short_d = 1'b1;
                        end
                        if (!sel_last && last_pld)
                            long_d = 1'b1;
                    end
                end
                if (pld_step) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_pld) begin
`ifdef TX_FRAME_CRC_EN
                        state_d = S_CRC;
                        idx_d   = '0;
                        if (long_d) drain_d = 1'b1;
`else
                        byte_last = 1'b1;
                        state_d   = long_d ? S_DRAIN : S_IDLE;
`endif
                    end
                end
            end
`ifdef TX_FRAME_CRC_EN
            S_CRC: begin
                if (load_ok) begin
                    byte_vld  = 1'b1;
                    byte_data = idx_q[0] ? crc_q[7:0] : crc_q[15:8];
                    if (idx_q[0]) begin
                        byte_last = 1'b1;
                        idx_d     = '0;
                        state_d   = drain_q ? S_DRAIN : S_IDLE;
                    end else begin
                        idx_d = 5'd1;
                    end
                end
            end
`endif
            S_DRAIN: begin
                // Discard the overrun tail; the output register is not touched.
                sel_ready = 1'b1;
                if (sel_valid && sel_last)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            pad_q     <= 1'b0;
            ptr_q     <= '0;
            cur_ch    <= '0;
            m_tvalid  <= 1'b0;
            m_tdata   <= 8'h00;
            m_tlast   <= 1'b0;
            m_tuser   <= 1'b0;
            hdr_vld   <= 1'b0;
            pld_vld   <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            pad_q     <= pad_d;
            ptr_q     <= ptr_d;
            cur_ch    <= cur_ch_d;
            err_short <= short_d;
            err_long  <= long_d;
            if (load_ok) begin
                m_tvalid <= byte_vld;
                m_tdata  <= byte_data;
                m_tlast  <= byte_last;
                m_tuser  <= byte_user;
                hdr_vld  <= byte_hdr;
                pld_vld  <= byte_pld;
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
`timescale 1ns/1ps
module tb_tx_frame_arbiter;
    import tx_frame_pkg::*;

    localparam int N_CH    = 2;
    localparam int LEN_W   = 16;
    localparam int MAX_LEN = 1024;
    localparam int PRE_LEN = 4;
`ifdef TX_FRAME_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  enable;
    logic [N_CH*8-1:0]     s_tdata;
    logic [N_CH-1:0]       s_tvalid;
    logic [N_CH-1:0]       s_tready;
    logic [N_CH-1:0]       s_tlast;
    logic [N_CH*LEN_W-1:0] s_len;
    logic [7:0]            m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;
    logic                  m_tuser;
    logic                  hdr_vld;
    logic                  pld_vld;
    logic [2:0]            cur_ch;
    logic                  pkt_sent;
    logic                  err_short;
    logic                  err_long;

    tx_frame_arbiter #(.N_CH(N_CH)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_len(s_len),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .hdr_vld(hdr_vld), .pld_vld(pld_vld), .cur_ch(cur_ch), .pkt_sent(pkt_sent),
        .err_short(err_short), .err_long(err_long)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       last;
        logic       user;
        logic       hdr;
        logic       pld;
        logic [7:0] data;
        logic       chk_ch;
        logic [2:0] ch;
    } exp_t;

    exp_t     exp_q[$];
    bit [8:0] src_q [N_CH][$];     // {tlast, data} per source byte
    int       src_len [N_CH][$];   // s_len presented for each source packet
    int checks = 0, errors = 0;
    int exp_short = 0, exp_long = 0, exp_pkts = 0;
    int n_short = 0, n_long = 0, n_pkts = 0;
    bit mon_en = 1'b0;
    bit rdy_rand = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit-serial CRC-16-CCITT reference.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic void push_exp(input logic [7:0] d, input logic user, input logic hdr,
                                     input logic pld, input logic last, input logic chk_ch,
                                     input logic [2:0] ch);
        exp_t e;
        e.data = d; e.user = user; e.hdr = hdr; e.pld = pld; e.last = last;
        e.chk_ch = chk_ch; e.ch = ch;
        exp_q.push_back(e);
    endfunction

    // Expected frame from the frame rules, plus the matching source packet.
    function automatic void add_job(input int ch, input int len_req, input logic [7:0] d[$]);
        int          l_eff;
        int          n;
        logic [15:0] l16;
        logic [15:0] crc;
        logic [7:0]  b;
        l_eff = (len_req > MAX_LEN) ? MAX_LEN : len_req;
        n     = d.size();
        l16   = 16'(l_eff);
        crc   = 16'hFFFF;
        for (int i = 0; i < PRE_LEN; i++) push_exp(8'h55, 1, 0, 0, 0, 0, 3'd0);
        b = 8'(ch);      push_exp(b, 1, 1, 0, 0, 1, 3'(ch)); crc = crc_step(crc, b);
        b = l16[15:8];   push_exp(b, 1, 1, 0, 0, 0, 3'd0);   crc = crc_step(crc, b);
        b = l16[7:0];    push_exp(b, 1, 1, 0, (l_eff == 0) && !CRC_ON, 0, 3'd0); crc = crc_step(crc, b);
        for (int k = 0; k < l_eff; k++) begin
            b = (k < n) ? d[k] : 8'h00;
            push_exp(b, 0, 0, 1, (k == l_eff - 1) && !CRC_ON, 0, 3'd0);
            crc = crc_step(crc, b);
        end
        if (CRC_ON) begin
            push_exp(crc[15:8], 0, 0, 0, 0, 0, 3'd0);
            push_exp(crc[7:0],  0, 0, 0, 1, 0, 3'd0);
        end
        for (int k = 0; k < n; k++) src_q[ch].push_back({(k == n - 1), d[k]});
        src_len[ch].push_back(len_req);
        if (n < l_eff) exp_short++;
        else if (n > l_eff && l_eff > 0) exp_long++;
        exp_pkts++;
    endfunction

    function automatic void rand_job(input int ch, input int len_req, input int n);
        logic [7:0] d[$];
        for (int k = 0; k < n; k++) d.push_back(8'($urandom));
        add_job(ch, len_req, d);
    endfunction

    function automatic void drive_sources();
        for (int c = 0; c < N_CH; c++) begin
            s_tvalid[c]             = (src_q[c].size() > 0);
            s_tdata[c*8 +: 8]       = (src_q[c].size() > 0) ? src_q[c][0][7:0] : 8'h00;
            s_tlast[c]              = (src_q[c].size() > 0) ? src_q[c][0][8] : 1'b0;
            s_len[c*LEN_W +: LEN_W] = (src_len[c].size() > 0) ? 16'(src_len[c][0]) : 16'h0000;
        end
    endfunction

    // Source/sink driver: handshakes sampled mid-cycle, inputs updated just after the edge.
    initial begin : driver
        bit hs [N_CH];
        forever begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) hs[c] = s_tvalid[c] && s_tready[c];
            @(posedge clk);
            #1;
            for (int c = 0; c < N_CH; c++) begin
                if (hs[c] && src_q[c].size() > 0) begin
                    if (src_q[c][0][8] && src_len[c].size() > 0) void'(src_len[c].pop_front());
                    void'(src_q[c].pop_front());
                end
            end
            drive_sources();
            m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard compare on every accepted output byte.
    initial begin : monitor
        exp_t       e;
        bit         stall_prev;
        logic [7:0] held;
        stall_prev = 1'b0;
        held       = 8'h00;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (stall_prev) check("hold_stable", {m_tvalid, m_tdata}, {1'b1, held});
                stall_prev = m_tvalid && !m_tready;
                held       = m_tdata;
                check("tready_onehot", $onehot0(s_tready), 1);
                if (err_short) n_short++;
                if (err_long)  n_long++;
                if (pkt_sent)  n_pkts++;
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", {m_tlast, m_tuser, hdr_vld, pld_vld, m_tdata},
                                            {e.last, e.user, e.hdr, e.pld, e.data});
                        check("pkt_sent", pkt_sent, e.last);
                        if (e.chk_ch) check("cur_ch", cur_ch, e.ch);
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] d[$];
        int cyc;
        rst_n = 1'b0; enable = 1'b0; m_tready = 1'b0;
        s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_len = '0;

        // Directed frames first, strictly alternating ch0/ch1 so rotation fixes the order.
        d = {}; d.push_back(8'h01); d.push_back(8'h02); d.push_back(8'h03);
        add_job(0, 3, d);
        rand_job(1, 2, 5);
        d = {}; d.push_back(8'hAA); d.push_back(8'hBB);
        add_job(0, 4, d);
        rand_job(1, 1030, 1024);
        for (int j = 0; j < 16; j++) begin
            for (int c = 0; c < N_CH; c++) begin
                int len_req;
                int kind;
                len_req = $urandom_range(1, 12);
                kind    = $urandom_range(0, 2);
                if (kind == 0 && len_req > 1) rand_job(c, len_req, $urandom_range(1, len_req - 1));
                else if (kind == 1)           rand_job(c, len_req, len_req + $urandom_range(1, 4));
                else                          rand_job(c, len_req, len_req);
            end
        end

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_outputs", {m_tvalid, m_tlast, m_tuser, hdr_vld, pld_vld, m_tdata, cur_ch, s_tready}, 0);

        // Sources are valid but enable is low: nothing may start.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("disabled_idle", m_tvalid, 0);
        end
        enable = 1'b1;

        cyc = 0;
        while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0) && cyc < 30000) begin
            @(negedge clk);
            cyc++;
        end
        check("main_frames_done", exp_q.size(), 0);
        check("sources_consumed", src_q[0].size() + src_q[1].size(), 0);

        // Zero-length frame on ch1: header only, source byte left untouched then withdrawn.
        d = {}; d.push_back(8'h77);
        add_job(1, 0, d);
        cyc = 0;
        while (!m_tvalid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("len0_granted", m_tvalid, 1);
        src_q[1].delete();
        src_len[1].delete();
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("len0_frame_done", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        check("err_short_count", n_short, exp_short);
        check("err_long_count", n_long, exp_long);
        check("pkt_sent_count", n_pkts, exp_pkts);

        // Reset in the middle of a frame aborts immediately.
        mon_en = 1'b0;
        for (int k = 0; k < 3; k++) src_q[1].push_back({(k == 2), 8'(k + 8'h10)});
        src_len[1].push_back(3);
        cyc = 0;
        while (!m_tvalid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_frame_started", m_tvalid, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_abort", {m_tvalid, m_tlast, m_tuser, hdr_vld, pld_vld, m_tdata, cur_ch,
                              s_tready, err_short, err_long, pkt_sent}, 0);
        src_q[1].delete();
        src_len[1].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
